// File: rtl/jt10_adpcm_rom_bridge.sv
// jt10_adpcm_rom_bridge: ADPCM-A/B byte fetch to 16-bit word memory bridge.
// Optional macro: JT10_ROMBRIDGE_STATS_EN enables per-channel miss counters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               one-cycle pulse, invalidates both line buffers
//   adpcma_addr/bank    ADPCM-A byte address {bank, addr}
//   adpcma_roe_n        ADPCM-A read enable (active low)
//   adpcma_data         ADPCM-A returned byte
//   adpcmb_addr         ADPCM-B byte address
//   adpcmb_roe_n        ADPCM-B read enable (active low)
//   adpcmb_data         ADPCM-B returned byte
//   mem_req/mem_addr    word read request, held until mem_ack
//   mem_ack/mem_rdata   one-cycle acknowledge with read word
//   miss_cnt_a/b        saturating fill-grant counters (0 when stats off)

module jt10_adpcm_rom_bridge #(
    parameter int              AW     = 25,
    parameter logic [AW-1:0]   A_BASE = 25'h0000000,
    parameter logic [AW-1:0]   B_BASE = 25'h1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [19:0]     adpcma_addr,
    input  logic [3:0]      adpcma_bank,
    input  logic            adpcma_roe_n,
    output logic [7:0]      adpcma_data,
    input  logic [23:0]     adpcmb_addr,
    input  logic            adpcmb_roe_n,
    output logic [7:0]      adpcmb_data,
    output logic            mem_req,
    output logic [AW-2:0]   mem_addr,
    input  logic            mem_ack,
    input  logic [15:0]     mem_rdata,
    output logic [15:0]     miss_cnt_a,
    output logic [15:0]     miss_cnt_b
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;

    // Address computation
    logic [AW-1:0]  w_a_byte;
    logic [AW-1:0]  w_b_byte;
    logic [AW-2:0]  w_a_tag;
    logic [AW-2:0]  w_b_tag;

    assign w_a_byte = A_BASE + AW'({adpcma_bank, adpcma_addr});
    assign w_b_byte = B_BASE + AW'(adpcmb_addr);
    assign w_a_tag  = w_a_byte[AW-1:1];
    assign w_b_tag  = w_b_byte[AW-1:1];

    // Line buffers
    logic [15:0]    r_a_line;
    logic [15:0]    r_b_line;
    logic [AW-2:0]  r_a_tag;
    logic [AW-2:0]  r_b_tag;
    logic           r_a_vld;
    logic           r_b_vld;

    logic           w_a_hit;
    logic           w_b_hit;
    logic           w_a_pend;
    logic           w_b_pend;

    assign w_a_hit  = !adpcma_roe_n && r_a_vld && (r_a_tag == w_a_tag);
    assign w_b_hit  = !adpcmb_roe_n && r_b_vld && (r_b_tag == w_b_tag);
    assign w_a_pend = !adpcma_roe_n && !w_a_hit;
    assign w_b_pend = !adpcmb_roe_n && !w_b_hit;

    // Request / arbitration state
    logic           r_req;
    logic [AW-2:0]  r_addr;
    logic           r_gnt_b;
    logic           r_last_b;
    logic           r_drop;

    logic           w_issue;
    logic           w_pick_b;
    logic           w_tie;
    logic           w_fill;
    logic           w_keep;

    always_comb begin
        w_state_nx = r_state;
        w_issue    = 1'b0;
        w_pick_b   = 1'b0;
        w_tie      = 1'b0;
        w_fill     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_a_pend || w_b_pend) begin
                    w_issue    = 1'b1;
                    w_state_nx = S_WAIT;
                    if (w_a_pend && w_b_pend) begin
                        // Tie: serve the channel not served last time.
                        w_tie    = 1'b1;
                        w_pick_b = !r_last_b;
                    end else begin
                        w_pick_b = w_b_pend;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    w_fill     = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // A fill is kept only if no flush hit it while in flight.
    assign w_keep = w_fill && !r_drop && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_gnt_b  <= 1'b0;
            r_last_b <= 1'b1;
            r_drop   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_req   <= 1'b1;
                r_addr  <= w_pick_b ? w_b_tag : w_a_tag;
                r_gnt_b <= w_pick_b;
                r_drop  <= 1'b0;
                if (w_tie) begin
                    r_last_b <= w_pick_b;
                end
            end else if (w_fill) begin
                r_req  <= 1'b0;
                r_drop <= 1'b0;
            end else if (flush && r_state == S_WAIT) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Channel A line and data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_line <= '0;
            r_a_tag  <= '0;
            r_a_vld  <= 1'b0;
        end else begin
            if (w_fill && !r_gnt_b) begin
                r_a_line <= mem_rdata;
                r_a_tag  <= r_addr;
            end
            if (flush) begin
                r_a_vld <= 1'b0;
            end else if (w_keep && !r_gnt_b) begin
                r_a_vld <= 1'b1;
            end
        end
    end

    logic [7:0] r_a_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_data <= '0;
        end else if (w_a_hit) begin
            r_a_data <= w_a_byte[0] ? r_a_line[15:8] : r_a_line[7:0];
        end
    end

    // Channel B line and data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_line <= '0;
            r_b_tag  <= '0;
            r_b_vld  <= 1'b0;
        end else begin
            if (w_fill && r_gnt_b) begin
                r_b_line <= mem_rdata;
                r_b_tag  <= r_addr;
            end
            if (flush) begin
                r_b_vld <= 1'b0;
            end else if (w_keep && r_gnt_b) begin
                r_b_vld <= 1'b1;
            end
        end
    end

    logic [7:0] r_b_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_data <= '0;
        end else if (w_b_hit) begin
            r_b_data <= w_b_byte[0] ? r_b_line[15:8] : r_b_line[7:0];
        end
    end

    assign adpcma_data = r_a_data;
    assign adpcmb_data = r_b_data;
    assign mem_req     = r_req;
    assign mem_addr    = r_addr;

`ifdef JT10_ROMBRIDGE_STATS_EN
    logic [15:0] r_cnt_a;
    logic [15:0] r_cnt_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else if (w_issue) begin
            if (!w_pick_b && r_cnt_a != 16'hFFFF) begin
                r_cnt_a <= r_cnt_a + 16'd1;
            end
            if (w_pick_b && r_cnt_b != 16'hFFFF) begin
                r_cnt_b <= r_cnt_b + 16'd1;
            end
        end
    end

    assign miss_cnt_a = r_cnt_a;
    assign miss_cnt_b = r_cnt_b;
`else
    assign miss_cnt_a = 16'h0000;
    assign miss_cnt_b = 16'h0000;
`endif

endmodule

// File: tb/tb_jt10_adpcm_rom_bridge.sv
// tb_jt10_adpcm_rom_bridge: directed and randomized bench for the
// ADPCM ROM bridge with a word-level memory and line-buffer model.

module tb_jt10_adpcm_rom_bridge;

    localparam int AW = 25;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [19:0] a_addr = '0;
    logic [3:0]  a_bank = '0;
    logic        a_roe_n = 1'b1;
    logic [23:0] b_addr = '0;
    logic        b_roe_n = 1'b1;
    wire  [7:0]  a_data;
    wire  [7:0]  b_data;
    wire         mem_req;
    wire  [23:0] mem_addr;
    wire         mem_ack;
    wire  [15:0] mem_rdata;
    wire  [15:0] cnt_a;
    wire  [15:0] cnt_b;

    int checks = 0;
    int errors = 0;

    // Memory contents as a function of word address
    function automatic logic [15:0] memf(input logic [23:0] w);
        return w[15:0] ^ {w[23:16], w[7:0]} ^ 16'h5A3C;
    endfunction

    function automatic logic [23:0] tag_a(input logic [3:0] bk,
                                          input logic [19:0] ad);
        logic [24:0] ba;
        ba = 25'h0000000 + {5'd0, bk, ad};
        return ba[24:1];
    endfunction

    function automatic logic [23:0] tag_b(input logic [23:0] ad);
        logic [24:0] ba;
        ba = 25'h1000000 + {1'b0, ad};
        return ba[24:1];
    endfunction

    function automatic logic [7:0] byte_of(input logic [15:0] w,
                                           input logic b0);
        return b0 ? w[15:8] : w[7:0];
    endfunction

    // Memory responder
    bit          auto_ack = 1'b1;
    int          lat = 2;
    int          wcnt = 0;
    logic        resp_ack = 1'b0;
    logic        man_ack = 1'b0;
    logic [15:0] man_data = '0;
    bit          force_en = 1'b0;
    logic [15:0] force_data = '0;
    logic [23:0] reqlog[$];

    assign mem_ack   = resp_ack | man_ack;
    assign mem_rdata = man_ack ? man_data :
                       force_en ? force_data : memf(mem_addr);

    always @(negedge clk) begin
        if (resp_ack) begin
            resp_ack = 1'b0;
        end else if (auto_ack && mem_req) begin
            if (wcnt >= lat) begin
                resp_ack = 1'b1;
                wcnt = 0;
                reqlog.push_back(mem_addr);
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    jt10_adpcm_rom_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .adpcma_addr  (a_addr),
        .adpcma_bank  (a_bank),
        .adpcma_roe_n (a_roe_n),
        .adpcma_data  (a_data),
        .adpcmb_addr  (b_addr),
        .adpcmb_roe_n (b_roe_n),
        .adpcmb_data  (b_data),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .miss_cnt_a   (cnt_a),
        .miss_cnt_b   (cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input string tag);
        int k;
        k = 0;
        while (resp_ack !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        chk(tag, {31'd0, resp_ack}, 32'd1);
    endtask

    logic [23:0] exp_log[4];
    logic [23:0] fw;
    logic [23:0] ta;
    logic [23:0] tb;
    logic [23:0] wa;
    logic [23:0] wb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    bit          va;
    bit          vb;
    int          n;
    int          k;
    int          na;
    int          nb;
    int          xa;
    int          xb;
    int          base;

    initial begin
        // Reset state
        step(3);
        chk("rst_req", {31'd0, mem_req}, 0);
        chk("rst_addr", {8'd0, mem_addr}, 0);
        chk("rst_a_data", {24'd0, a_data}, 0);
        chk("rst_b_data", {24'd0, b_data}, 0);
        rst = 1'b0;
        step();

        // Cold miss on A
        lat = 3;
        force_en = 1'b1;
        force_data = 16'hBEEF;
        a_bank = 4'h1;
        a_addr = 20'h00003;
        a_roe_n = 1'b0;
        step();
        chk("cold_req", {31'd0, mem_req}, 1);
        chk("cold_addr", {8'd0, mem_addr}, 32'h080001);
        wait_ack("cold_ack");
        step();
        chk("cold_hold", {24'd0, a_data}, 0);
        chk("cold_req_drop", {31'd0, mem_req}, 0);
        step();
        chk("cold_data", {24'd0, a_data}, 32'hBE);

        // Hit on the other byte of the same word
        a_addr = 20'h00002;
        step();
        chk("hit_data", {24'd0, a_data}, 32'hEF);
        chk("hit_noreq", {31'd0, mem_req}, 0);
        step(2);
        chk("hit_noreq2", {31'd0, mem_req}, 0);
        force_en = 1'b0;

        // Contention: both channels keep moving to new words
        lat = 2;
        reqlog.delete();
        a_bank = 4'h2;
        a_addr = 20'h00010;
        b_addr = 24'h000100;
        b_roe_n = 1'b0;
        exp_log[0] = tag_a(4'h2, 20'h00010);
        exp_log[1] = tag_b(24'h000100);
        exp_log[2] = tag_a(4'h2, 20'h00020);
        exp_log[3] = tag_b(24'h000110);
        n = 0;
        k = 0;
        while (reqlog.size() < 4 && k < 80) begin
            step();
            k++;
            if (reqlog.size() > n) begin
                n = reqlog.size();
                if (reqlog[n-1][23]) b_addr = b_addr + 24'h10;
                else a_addr = a_addr + 20'h10;
            end
        end
        a_roe_n = 1'b1;
        b_roe_n = 1'b1;
        chk("cont_count", reqlog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont_grant%0d", i),
                {8'd0, (reqlog.size() > i) ? reqlog[i] : 24'hxxxxxx},
                {8'd0, exp_log[i]});
        end
        chk("cont_b_first", {8'd0, exp_log[1]}, 32'h800080);
        step(12);
        chk("cont_idle", {31'd0, mem_req}, 0);

        // Flush while A's request is in flight
        lat = 3;
        a_bank = 4'h3;
        a_addr = 20'h00040;
        a_roe_n = 1'b0;
        fw = tag_a(4'h3, 20'h00040);
        step();
        chk("fl_req", {31'd0, mem_req}, 1);
        chk("fl_addr", {8'd0, mem_addr}, {8'd0, fw});
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_ack("fl_ack");
        step();
        chk("fl_gap", {31'd0, mem_req}, 0);
        step();
        chk("fl_rereq", {31'd0, mem_req}, 1);
        chk("fl_readdr", {8'd0, mem_addr}, {8'd0, fw});
        chk("fl_hold", {24'd0, a_data}, 32'hEF);
        wait_ack("fl_ack2");
        step(2);
        chk("fl_data", {24'd0, a_data}, {24'd0, byte_of(memf(fw), 1'b0)});

        // Reset in WAIT, then a stray ack
        auto_ack = 1'b0;
        a_bank = 4'h4;
        a_addr = 20'h00101;
        step();
        chk("rs_req", {31'd0, mem_req}, 1);
        rst = 1'b1;
        step();
        chk("rs_req0", {31'd0, mem_req}, 0);
        chk("rs_addr0", {8'd0, mem_addr}, 0);
        chk("rs_a_data", {24'd0, a_data}, 0);
        chk("rs_b_data", {24'd0, b_data}, 0);
        rst = 1'b0;
        a_roe_n = 1'b1;
        step();
        man_data = 16'h1234;
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        a_bank = 4'h0;
        a_addr = 20'h00000;
        a_roe_n = 1'b0;
        step();
        chk("rs_stray_miss", {31'd0, mem_req}, 1);
        chk("rs_stray_hold", {24'd0, a_data}, 0);
        auto_ack = 1'b1;
        wait_ack("rs_ack");
        step(2);
        chk("rs_data", {24'd0, a_data},
            {24'd0, byte_of(memf(24'h0), 1'b0)});

        // Randomized phase against a line-buffer model
        va = 1'b1;
        wa = 24'h0;
        ea = byte_of(memf(24'h0), 1'b0);
        vb = 1'b0;
        wb = 24'h0;
        eb = 8'h00;
        for (int it = 0; it < 40; it++) begin
            lat = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                flush = 1'b1;
                step();
                flush = 1'b0;
                va = 1'b0;
                vb = 1'b0;
            end
            a_roe_n = ($urandom_range(0, 3) == 0);
            b_roe_n = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                a_addr = {a_addr[19:1], 1'($urandom_range(0, 1))};
            end else begin
                a_bank = 4'($urandom);
                a_addr = 20'($urandom);
            end
            if ($urandom_range(0, 1) == 1) begin
                b_addr = {b_addr[23:1], 1'($urandom_range(0, 1))};
            end else begin
                b_addr = 24'($urandom);
            end
            ta = tag_a(a_bank, a_addr);
            tb = tag_b(b_addr);
            xa = (!a_roe_n && !(va && wa == ta)) ? 1 : 0;
            xb = (!b_roe_n && !(vb && wb == tb)) ? 1 : 0;
            base = reqlog.size();
            step(20);
            na = 0;
            nb = 0;
            for (int j = base; j < reqlog.size(); j++) begin
                if (reqlog[j][23]) nb++;
                else na++;
            end
            if (!a_roe_n) begin
                va = 1'b1;
                wa = ta;
                ea = byte_of(memf(ta), a_addr[0]);
            end
            if (!b_roe_n) begin
                vb = 1'b1;
                wb = tb;
                eb = byte_of(memf(tb), b_addr[0]);
            end
            chk($sformatf("rnd%0d_reqs_a", it), na, xa);
            chk($sformatf("rnd%0d_reqs_b", it), nb, xb);
            chk($sformatf("rnd%0d_a_data", it), {24'd0, a_data}, {24'd0, ea});
            chk($sformatf("rnd%0d_b_data", it), {24'd0, b_data}, {24'd0, eb});
        end

`ifdef JT10_ROMBRIDGE_STATS_EN
        // Counter saturation on B
        a_roe_n = 1'b1;
        b_roe_n = 1'b1;
        step(12);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("st_rst_a", {16'd0, cnt_a}, 0);
        chk("st_rst_b", {16'd0, cnt_b}, 0);
        lat = 0;
        b_roe_n = 1'b0;
        n = 0;
        for (int i = 0; i < 70000; i++) begin
            b_addr = {i[22:0], 1'b0};
            k = 0;
            while (resp_ack !== 1'b1 && k < 10) begin
                step();
                k++;
            end
            if (resp_ack !== 1'b1) n++;
        end
        b_roe_n = 1'b1;
        step(4);
        chk("st_timeouts", n, 0);
        chk("st_cnt_b", {16'd0, cnt_b}, 32'hFFFF);
        chk("st_cnt_a", {16'd0, cnt_a}, 0);
`else
        chk("nostats_a", {16'd0, cnt_a}, 0);
        chk("nostats_b", {16'd0, cnt_b}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
